spi_byte_rx: RTL and testbench

SPI_BYTE_RX -- requirements
Module: spi_byte_rx

---
 rtl/spi_byte_rx.sv | 194 +++++++++++++++++++
 tb/tb_spi_byte_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver with a small receive FIFO and a sticky overflow flag.
// Define SPI_ECHO_EN to echo the last received byte on miso during the next frame.
module spi_byte_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       ovf,
    input  logic       ovf_clr,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Idle levels of {mosi, cs, sclk} held by the synchronizers during reset
    localparam logic [2:0] SYNC_IDLE = 3'b010;

    logic [2:0] async_in;
    logic [2:0] sync_s;
    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_d_reg;
    logic       sclk_rise;

    assign async_in = {mosi, cs, sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [1:0] chain_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg <= {SYNC_IDLE[gi], SYNC_IDLE[gi]};
                end else begin
                    chain_reg <= {chain_reg[0], async_in[gi]};
                end
            end
            assign sync_s[gi] = chain_reg[1];
        end
    endgenerate

    assign sclk_s = sync_s[0];
    assign cs_s   = sync_s[1];
    assign mosi_s = sync_s[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d_reg <= 1'b0;
        end else begin
            sclk_d_reg <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign busy      = ~cs_s;

    // Bit assembly: holding the counter at zero while cs is high also
    // discards any partial byte left by an early cs release.
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] push_byte;
    logic       push;

    always_comb begin
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        push         = 1'b0;
        push_byte    = {shift_reg[6:0], mosi_s};
        if (cs_s) begin
            bit_cnt_next = 3'd0;
        end else if (sclk_rise) begin
            shift_next   = push_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            push         = (bit_cnt_reg == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Receive FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ovf_reg, ovf_next;
    logic          full;
    logic          rd_fire;
    logic          wr_en;
    logic          ovf_set;

    assign full     = (count_reg == CW'(FIFO_DEPTH));
    assign rd_valid = (count_reg != '0);
    assign rd_fire  = rd_ready & rd_valid;
    // A full FIFO still accepts a byte when the head is popped in the same cycle
    assign wr_en    = push & (~full | rd_fire);
    assign ovf_set  = push & full & ~rd_fire;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({wr_en, rd_fire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_byte;
        end
    end

    // Empty FIFO presents zero so stale storage never leaks onto rd_data
    assign rd_data = rd_valid ? mem[rd_ptr_reg] : 8'h00;
    assign ovf     = ovf_reg;

`ifdef SPI_ECHO_EN
    logic       cs_d_reg;
    logic       cs_fall;
    logic       sclk_fall;
    logic [7:0] last_reg;
    logic [7:0] tx_reg;

    assign cs_fall   = ~cs_s & cs_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_d_reg <= 1'b1;
            last_reg <= 8'h00;
            tx_reg   <= 8'h00;
        end else begin
            cs_d_reg <= cs_s;
            if (push) begin
                last_reg <= push_byte;
            end
            if (cs_fall) begin
                tx_reg <= last_reg;
            end else if (!cs_s && sclk_fall) begin
                tx_reg <= {tx_reg[6:0], 1'b0};
            end
        end
    end

    assign miso = tx_reg[7];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: SPI frames at 62 ns half-period against a 50 MHz clk.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    logic [7:0] miso_cap = 8'h00;
    logic       miso_seen = 1'b0;

    spi_byte_rx #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        $display("check %s: observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clocks out the top n bits of b, MSB first; samples miso just before each rising edge
    task automatic sclk_bits(input logic [7:0] b, input int n, input logic lat_chk);
        @(negedge clk);
        #3;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #62;
            miso_cap  = {miso_cap[6:0], miso};
            miso_seen = miso_seen | miso;
            sclk = 1'b1;
            #62;
            sclk = 1'b0;
            if (lat_chk && i == n - 1) begin
                #19;
                check("latency_valid", {7'd0, rd_valid}, 8'd1);
                check("latency_data", rd_data, b);
                #43;
            end else begin
                #62;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic cs_level, input logic lat_chk);
        @(negedge clk);
        #3;
        cs = cs_level;
        #62;
        check("busy", {7'd0, busy}, {7'd0, ~cs_level});
        sclk_bits(b, 8, lat_chk);
        #62;
        cs = 1'b1;
        #124;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, rd_data, exp);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    initial begin
        #35;
        check("rst_valid", {7'd0, rd_valid}, 8'd0);
        check("rst_data", rd_data, 8'h00);
        check("rst_ovf", {7'd0, ovf}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_miso", {7'd0, miso}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single byte with latency check
        send_byte(8'hAA, 1'b0, 1'b1);
        @(negedge clk);
        check("aa_ovf", {7'd0, ovf}, 8'd0);
        pop_check("aa_data", 8'hAA);
        check("aa_empty", {7'd0, rd_valid}, 8'd0);

        // three queued bytes, head held stable until popped
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("q_head", rd_data, 8'h33);
        repeat (3) @(negedge clk);
        check("q_hold", rd_data, 8'h33);
        pop_check("q_0", 8'h33);
        check("q_valid1", {7'd0, rd_valid}, 8'd1);
        pop_check("q_1", 8'hFF);
        check("q_valid2", {7'd0, rd_valid}, 8'd1);
        pop_check("q_2", 8'h00);
        check("q_empty", {7'd0, rd_valid}, 8'd0);

        // clock pulses with cs high are ignored
        send_byte(8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        check("cs_hi_valid", {7'd0, rd_valid}, 8'd0);
        check("cs_hi_busy", {7'd0, busy}, 8'd0);

        // overflow: fifth byte dropped
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ovf", {7'd0, ovf}, 8'd0);
        send_byte(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_set", {7'd0, ovf}, 8'd1);
        repeat (2) @(negedge clk);
        check("ovf_sticky", {7'd0, ovf}, 8'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", {7'd0, ovf}, 8'd0);
        pop_check("ovf_0", 8'h11);
        pop_check("ovf_1", 8'h22);
        pop_check("ovf_2", 8'h33);
        pop_check("ovf_3", 8'h44);
        check("ovf_empty", {7'd0, rd_valid}, 8'd0);

        // partial byte discarded on cs release
        @(negedge clk);
        #3;
        cs = 1'b0;
        #62;
        sclk_bits(8'hB8, 5, 1'b0);
        #62;
        cs = 1'b1;
        #124;
        check("part_valid", {7'd0, rd_valid}, 8'd0);
        send_byte(8'h5A, 1'b0, 1'b0);
        pop_check("part_5a", 8'h5A);
        check("part_empty", {7'd0, rd_valid}, 8'd0);

        // reset mid-byte with cs still low
        @(negedge clk);
        #3;
        cs = 1'b0;
        #62;
        sclk_bits(8'hE0, 3, 1'b0);
        #20;
        rst_n = 1'b0;
        #40;
        check("mid_rst_valid", {7'd0, rd_valid}, 8'd0);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #62;
        sclk_bits(8'h96, 8, 1'b0);
        #62;
        cs = 1'b1;
        #124;
        pop_check("mid_rst_96", 8'h96);
        check("mid_rst_empty", {7'd0, rd_valid}, 8'd0);

        // echo of the previous byte on miso
        send_byte(8'hC3, 1'b0, 1'b0);
        pop_check("echo_c3", 8'hC3);
        miso_cap = 8'h00;
        send_byte(8'h00, 1'b0, 1'b0);
`ifdef SPI_ECHO_EN
        check("echo_miso", miso_cap, 8'hC3);
`else
        check("miso_zero", {7'd0, miso_seen}, 8'd0);
`endif
        pop_check("echo_00", 8'h00);
        check("echo_empty", {7'd0, rd_valid}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
